// File: rtl/exec_alu_stage.sv
// Execute stage between register-file read ports and its write port.
// Single-cycle ALU ops plus a sequential shift-add signed multiply.
module exec_alu_stage #(
  parameter int DATA_W   = 10,
  parameter int REG_AW   = 4,
  parameter int NUM_REGS = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [REG_AW-1:0] i_dst,
  output logic              o_done,
  output logic [REG_AW-1:0] o_reg2,
  output logic [DATA_W-1:0] o_data2,
  output logic              o_ovf
);

  // state  | meaning
  // S_IDLE | accepting requests; non-MUL ops complete on the accept edge
  // S_MUL  | shift-add iterations in progress, requests ignored
  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SAR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);
  localparam logic [REG_AW-1:0] MAX_REG  = REG_AW'(NUM_REGS);

  state_t state, state_nxt;

  logic accept, mul_req, mul_last;
  logic dst_ok;
  logic [REG_AW-1:0] dst_eff;

  assign o_ready  = (state == S_IDLE);
  assign accept   = i_valid & o_ready;
  assign mul_req  = accept && (i_op == OP_MUL);

  assign dst_ok  = (i_dst != '0) && (i_dst <= MAX_REG);
  assign dst_eff = dst_ok ? i_dst : '0;

  // Multiplier datapath registers
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic              neg_q;
  logic [REG_AW-1:0] dst_q;

  assign mul_last = (state == S_MUL) && (cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mul_req)  state_nxt = S_MUL;
      S_MUL:   if (mul_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle ALU
  logic [DATA_W-1:0] sum, diff, alu_res;
  logic              alu_ovf;
  logic [3:0]        shamt;
  logic              shift_big;

  assign sum       = i_a + i_b;
  assign diff      = i_a - i_b;
  assign shamt     = i_b[3:0];
  assign shift_big = (32'(shamt) >= 32'(DATA_W));

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (i_op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (sum[DATA_W-1] != i_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (diff[DATA_W-1] != i_a[DATA_W-1]);
      end
      OP_AND: alu_res = i_a & i_b;
      OP_OR:  alu_res = i_a | i_b;
      OP_XOR: alu_res = i_a ^ i_b;
      OP_SHL: alu_res = shift_big ? '0 : (i_a << shamt);
      OP_SAR: alu_res = shift_big ? {DATA_W{i_a[DATA_W-1]}}
                                  : DATA_W'($signed(i_a) >>> shamt);
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Operand magnitudes; the most negative value maps to 2^(DATA_W-1), still fits unsigned
  logic [DATA_W-1:0] mag_a, mag_b;
  assign mag_a = i_a[DATA_W-1] ? (~i_a + 1'b1) : i_a;
  assign mag_b = i_b[DATA_W-1] ? (~i_b + 1'b1) : i_b;

  logic [PROD_W-1:0] acc_nxt, prod;
  logic [PROD_W-DATA_W:0] prod_hi;
  logic              mul_ovf;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign prod    = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
  assign prod_hi = prod[PROD_W-1:DATA_W-1];
  // Product fits only if the upper half plus result sign bit are all equal
  assign mul_ovf = !((&prod_hi) || !(|prod_hi));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg_q  <= 1'b0;
      dst_q  <= '0;
    end else if (mul_req) begin
      cnt    <= CNT_LOAD;
      acc    <= '0;
      mcand  <= {{(PROD_W-DATA_W){1'b0}}, mag_a};
      mplier <= mag_b;
      neg_q  <= i_a[DATA_W-1] ^ i_b[DATA_W-1];
      dst_q  <= dst_eff;
    end else if (state == S_MUL) begin
      cnt    <= cnt - 1'b1;
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_done  <= 1'b0;
      o_reg2  <= '0;
      o_data2 <= '0;
      o_ovf   <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_reg2  <= '0;
      o_data2 <= '0;
      o_ovf   <= 1'b0;
      if (accept && (i_op != OP_MUL)) begin
        o_done  <= 1'b1;
        o_reg2  <= dst_eff;
        o_data2 <= alu_res;
        o_ovf   <= alu_ovf;
      end else if (mul_last) begin
        o_done  <= 1'b1;
        o_reg2  <= dst_q;
        o_data2 <= prod[DATA_W-1:0];
        o_ovf   <= mul_ovf;
      end
    end
  end

endmodule
